sram_port0_ctrl: RTL

SRAM_PORT0_CTRL -- requirements
Module: sram_port0_ctrl

---
 rtl/sram_port0_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_port0_ctrl.sv
// ---------------------------------------------------------------------------
// sram_port0_ctrl
//
// Request/response front end for port 0 of a single-port SRAM macro.
// After reset the block optionally sweeps the whole macro with zero writes
// (INIT). It then accepts read/write requests (RUN). Reads return through
// a small response FIFO whose depth also bounds the number of reads that
// may be outstanding, so the FIFO can never overflow.
//
// Ports
//   clk0, rst0                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_we, req_wmask,
//   req_addr, req_wdata        request payload (write when req_we=1)
//   rsp_valid/rsp_ready        response handshake, rsp_rdata = FIFO head
//   init_done                  high once the clear sweep is finished
//   csb0, web0, wmask0,
//   addr0, din0                registered macro controls (active-low selects)
//   dout0                      macro read data, valid two edges after accept
// ---------------------------------------------------------------------------
module sram_port0_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int PEND_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e RESET_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  // FSM and sweep address
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;

  // Registered macro controls
  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;

  // Read pipeline: rd1 = read presented to macro, rd2 = dout0 valid this cycle
  logic                  rd1_q, rd2_q;
  logic                  rd_issue;

  // Response FIFO
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [PEND_W-1:0]     pending;
  logic                  accept, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Every read that has been accepted but not yet popped holds a credit,
  // whether it is still in the macro pipeline or already in the FIFO.
  assign pending = {1'b0, count_q} + PEND_W'(rd1_q) + PEND_W'(rd2_q);

  // Handshake outputs are gated by rst0 so they are low for the whole reset
  // cycle, not only after the first reset edge.
  assign init_done = (state_q == ST_RUN) && !rst0;
  assign req_ready = init_done && (pending < PEND_W'(RSP_DEPTH));
  assign rsp_valid = (count_q != '0) && !rst0;
  assign rsp_rdata = fifo_q[rd_ptr_q];

  assign accept = req_valid && req_ready;
  assign push   = rd2_q;
  assign pop    = rsp_valid && rsp_ready;

  assign csb0   = csb0_q;
  assign web0   = web0_q;
  assign wmask0 = wmask0_q;
  assign addr0  = addr0_q;
  assign din0   = din0_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    init_addr_d = init_addr_q;
    csb0_d      = 1'b1;
    web0_d      = 1'b1;
    wmask0_d    = '0;
    addr0_d     = '0;
    din0_d      = '0;
    rd_issue    = 1'b0;

    case (state_q)
      ST_INIT: begin
        csb0_d      = 1'b0;
        web0_d      = 1'b0;
        wmask0_d    = '1;
        addr0_d     = init_addr_q;
        init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        if (init_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (req_we) begin
            // An all-zero mask is consumed without touching the macro.
            if (req_wmask != '0) begin
              csb0_d   = 1'b0;
              web0_d   = 1'b0;
              wmask0_d = req_wmask;
              addr0_d  = req_addr;
              din0_d   = req_wdata;
            end
          end else begin
            csb0_d   = 1'b0;
            addr0_d  = req_addr;
            rd_issue = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q     <= RESET_STATE;
      init_addr_q <= '0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      wmask0_q    <= '0;
      addr0_q     <= '0;
      din0_q      <= '0;
      rd1_q       <= 1'b0;
      rd2_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      // NOTE: the FIFO storage is reset (it is only a few words) so that
      // rsp_rdata reads as zero after reset instead of stale data.
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      wmask0_q    <= wmask0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      rd1_q       <= rd_issue;
      rd2_q       <= rd1_q;

      if (push) begin
        fifo_q[wr_ptr_q] <= dout0;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
